// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for an 8:1 single-bit data mux.
// Grants one requesting channel at a time, for at most MAX_HOLD accepted beats.
module mux_sel_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ready,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic       valid,
   output logic       last
);

   // state | meaning
   // IDLE  | no channel granted, waiting for any request
   // GRANT | channel sel is on the mux, counting accepted beats
   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [HOLD_W-1:0] CNT_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state, next_state;
   logic [2:0]        ptr, next_ptr;
   logic [2:0]        next_sel;
   logic [7:0]        next_grant;
   logic              next_valid;
   logic [HOLD_W-1:0] cnt, next_cnt;
   logic [2:0]        start, pick;
   logic              beat, burst_end;

   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] from);
      logic [2:0] idx;
      logic       found;
      rr_pick = from;
      found   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = from + 3'(i);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Outside a burst the search starts at ptr; at burst end the current channel goes last.
   assign start     = (state == IDLE) ? ptr : sel + 3'd1;
   assign pick      = rr_pick(req, start);
   assign beat      = valid & ready;
   assign burst_end = !req[sel] || (beat && cnt == CNT_LAST);
   assign last      = valid && (cnt == CNT_LAST);

   always_comb begin
      next_state = state;
      next_ptr   = ptr;
      next_sel   = sel;
      next_grant = grant;
      next_valid = valid;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            next_grant = 8'h00;
            next_valid = 1'b0;
            if (|req) begin
               next_state = GRANT;
               next_sel   = pick;
               next_grant = 8'b1 << pick;
               next_valid = 1'b1;
               next_cnt   = '0;
            end
         end
         GRANT: begin
            if (burst_end) begin
               next_ptr = sel + 3'd1;
               next_cnt = '0;
               if (|req) begin
                  next_sel   = pick;
                  next_grant = 8'b1 << pick;
                  next_valid = 1'b1;
               end else begin
                  next_state = IDLE;
                  next_grant = 8'h00;
                  next_valid = 1'b0;
               end
            end else if (beat) begin
               next_cnt = cnt + 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            next_grant = 8'h00;
            next_valid = 1'b0;
            next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 3'd0;
         sel   <= 3'd0;
         grant <= 8'h00;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= next_state;
         ptr   <= next_ptr;
         sel   <= next_sel;
         grant <= next_grant;
         valid <= next_valid;
         cnt   <= next_cnt;
      end
   end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with MAX_HOLD=4; expected values are hand-computed.
module tb_mux_sel_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       ready;
   logic [2:0] sel;
   logic [7:0] grant;
   logic       valid;
   logic       last;

   int n_cmp = 0;
   int n_err = 0;

   mux_sel_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .ready (ready),
      .sel   (sel),
      .grant (grant),
      .valid (valid),
      .last  (last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic exp_valid, input logic [2:0] exp_sel,
                          input logic [7:0] exp_grant, input logic exp_last);
      chk({tag, ".valid"}, 32'(valid), 32'(exp_valid));
      chk({tag, ".sel"},   32'(sel),   32'(exp_sel));
      chk({tag, ".grant"}, 32'(grant), 32'(exp_grant));
      chk({tag, ".last"},  32'(last),  32'(exp_last));
   endtask

   initial begin
      logic [2:0] s;

      // idle after reset
      rst = 1'b1; req = 8'h00; ready = 1'b0;
      tick(); tick();
      chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_out("idle", 1'b0, 3'd0, 8'h00, 1'b0);
      end

      // single requester: re-granted every 4 beats without a gap
      req = 8'h01; ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk_out("single", 1'b1, 3'd0, 8'h01, (k % 4) == 3);
      end
      req = 8'h00;
      tick();
      chk_out("single_drop", 1'b0, 3'd0, 8'h00, 1'b0);

      // all requesting: four beats per channel, wrapping 7 -> 0
      rst = 1'b1; tick(); rst = 1'b0;
      req = 8'hFF; ready = 1'b1;
      for (int k = 0; k < 36; k++) begin
         tick();
         s = 3'((k / 4) % 8);
         chk_out("all", 1'b1, s, 8'b1 << s, (k % 4) == 3);
      end

      // backpressure holds everything, then 4 beats hand off to ch5
      rst = 1'b1; tick(); rst = 1'b0;
      req = 8'h24; ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("stall", 1'b1, 3'd2, 8'h04, 1'b0);
      end
      ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_out("drain", 1'b1, 3'd2, 8'h04, k == 3);
         tick();
      end
      chk_out("handoff", 1'b1, 3'd5, 8'h20, 1'b0);

      // early drop of ch3 after two beats
      rst = 1'b1; tick(); rst = 1'b0;
      req = 8'h48; ready = 1'b1;
      tick();
      chk_out("ch3_b0", 1'b1, 3'd3, 8'h08, 1'b0);
      tick();
      tick();
      chk_out("ch3_b2", 1'b1, 3'd3, 8'h08, 1'b0);
      req = 8'h40;
      tick();
      chk_out("drop_b0", 1'b1, 3'd6, 8'h40, 1'b0);
      tick();
      chk_out("drop_b1", 1'b1, 3'd6, 8'h40, 1'b0);
      tick();
      chk_out("drop_b2", 1'b1, 3'd6, 8'h40, 1'b0);
      tick();
      chk_out("drop_b3", 1'b1, 3'd6, 8'h40, 1'b1);

      // reset mid-burst on ch5, then ptr restarts at 0
      req = 8'h20;
      tick();
      chk_out("ch5", 1'b1, 3'd5, 8'h20, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      rst = 1'b0; req = 8'h82;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out("post_rst_ch1", 1'b1, 3'd1, 8'h02, k == 3);
      end
      tick();
      chk_out("post_rst_ch7", 1'b1, 3'd7, 8'h80, 1'b0);

      // drop to idle: sel holds, ready ignored
      req = 8'h00;
      tick();
      chk_out("idle_hold", 1'b0, 3'd7, 8'h00, 1'b0);
      ready = 1'b0;
      tick();
      chk_out("idle_hold2", 1'b0, 3'd7, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
